// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
package period_meter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a delay flop, giving single-cycle rise/fall
// pulses for an input that is asynchronous to clk.
module sync_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  // Synchronizer chain (s1, s2) followed by the edge-detect delay flop (s3).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;
  assign fall = ~s2_reg & s3_reg;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous waveform in clk
// cycles. A measurement spans two consecutive synchronized rising edges;
// results are latched on entry to DONE and held until the next DONE.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TIMEOUT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             overflow
);

  logic rise;
  logic fall;

  sync_edge_detect u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] cnt_reg,    cnt_next;
  logic [WIDTH-1:0] hcnt_reg,   hcnt_next;
  logic             fell_reg,   fell_next;
  logic [WIDTH-1:0] period_reg, high_reg;
  logic             ovf_reg;

  logic             load;
  logic [WIDTH-1:0] load_period;
  logic [WIDTH-1:0] load_high;
  logic             load_ovf;

  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] hcnt_inc;

  // Saturating increments: the counters stop at TIMEOUT and never wrap.
  assign cnt_inc  = (cnt_reg  >= TIMEOUT) ? TIMEOUT : cnt_reg  + 1'b1;
  assign hcnt_inc = (hcnt_reg >= TIMEOUT) ? TIMEOUT : hcnt_reg + 1'b1;

  // Next-state, counter and result-load decisions.
  // Results use the counter values as they stand after this cycle's
  // increment, so a timeout reports exactly TIMEOUT cycles.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hcnt_next   = hcnt_reg;
    fell_next   = fell_reg;
    load        = 1'b0;
    load_period = '0;
    load_high   = '0;
    load_ovf    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        hcnt_next = '0;
        fell_next = 1'b0;
        if (start) begin
          state_next = ARM;
        end
      end

      ARM: begin
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = '0;
          hcnt_next  = '0;
          fell_next  = 1'b0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc >= TIMEOUT) begin
            state_next  = DONE;
            load        = 1'b1;
            load_period = TIMEOUT;
            load_high   = hcnt_reg;
            load_ovf    = 1'b1;
          end
        end
      end

      MEASURE: begin
        cnt_next = cnt_inc;
        // High time counts up to and including the first fall, then freezes.
        if (!fell_reg) begin
          hcnt_next = hcnt_inc;
        end
        if (fall) begin
          fell_next = 1'b1;
        end
        if (rise) begin
          state_next  = DONE;
          load        = 1'b1;
          load_period = cnt_inc;
          // No fall seen: the waveform was high for the whole period.
          load_high   = fell_reg ? hcnt_reg : cnt_inc;
          load_ovf    = 1'b0;
        end else if (cnt_inc >= TIMEOUT) begin
          state_next  = DONE;
          load        = 1'b1;
          load_period = TIMEOUT;
          load_high   = fell_reg ? hcnt_reg : hcnt_inc;
          load_ovf    = 1'b1;
        end
      end

      DONE: begin
        cnt_next  = '0;
        hcnt_next = '0;
        fell_next = 1'b0;
        state_next = start ? ARM : IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and held result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hcnt_reg   <= '0;
      fell_reg   <= 1'b0;
      period_reg <= '0;
      high_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hcnt_reg  <= hcnt_next;
      fell_reg  <= fell_next;
      if (load) begin
        period_reg <= load_period;
        high_reg   <= load_high;
        ovf_reg    <= load_ovf;
      end
    end
  end

  assign busy      = (state_reg == ARM) || (state_reg == MEASURE);
  assign done      = (state_reg == DONE);
  assign period    = period_reg;
  assign high_time = high_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter. Two instances share clk, resetn and sig_in:
// dut_a uses the default width and timeout, dut_t a short TIMEOUT of 50.
// sig_in is driven as a periodic square wave (or a constant level) that
// changes just after each rising clk edge; the expected period is simply
// high + low length and the expected high time the high length.
module tb_period_meter;

  localparam int              WA   = 32;
  localparam int              WT   = 8;
  localparam logic [WT-1:0]   TO_T = 8'd50;

  logic          clk     = 1'b0;
  logic          resetn  = 1'b0;
  logic          sig_in  = 1'b0;
  logic          start_a = 1'b0;
  logic          start_t = 1'b0;

  logic          busy_a, done_a, ovf_a;
  logic [WA-1:0] period_a, high_a;
  logic          busy_t, done_t, ovf_t;
  logic [WT-1:0] period_t, high_t;

  always #5 clk = ~clk;

  period_meter #(.WIDTH(WA)) dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .sig_in    (sig_in),
    .start     (start_a),
    .busy      (busy_a),
    .done      (done_a),
    .period    (period_a),
    .high_time (high_a),
    .overflow  (ovf_a)
  );

  period_meter #(.WIDTH(WT), .TIMEOUT(TO_T)) dut_t (
    .clk       (clk),
    .resetn    (resetn),
    .sig_in    (sig_in),
    .start     (start_t),
    .busy      (busy_t),
    .done      (done_t),
    .period    (period_t),
    .high_time (high_t),
    .overflow  (ovf_t)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   wh           = 5;
  int   wl           = 5;
  int   wph          = 0;
  bit   wave_on      = 1'b0;
  logic wlevel       = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: outputs are sampled 1 time unit after the rising edge,
  // and sig_in is updated at that same point from the waveform description.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wave_on) sig_in = ((cyc + wph) % (wh + wl)) < wh;
    else         sig_in = wlevel;
  endtask

  // Select a new square wave with random phase and let it run one full
  // period so no glitch from the switch-over is in flight.
  task automatic set_wave(input int h, input int l);
    wh      = h;
    wl      = l;
    wph     = int'($urandom_range(0, h + l - 1));
    wave_on = 1'b1;
    repeat (h + l + 4) tick();
  endtask

  function automatic logic done_of(input bit sel);
    return sel ? done_t : done_a;
  endfunction

  // Tick until the selected instance pulses done (at most 'bound' cycles).
  // mode 0: start is a one-cycle pulse; 1: start toggles randomly while
  // busy and is dropped as done appears; 2: start is left as it is.
  task automatic run(input bit sel, input int bound, input int mode, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      if (mode == 0) begin
        start_a = 1'b0;
        start_t = 1'b0;
      end else if (mode == 1) begin
        if (done_of(sel) === 1'b1) begin
          start_a = 1'b0;
          start_t = 1'b0;
        end else begin
          start_a = 1'($urandom_range(0, 1));
          start_t = start_a;
        end
      end
    end while (done_of(sel) !== 1'b1 && lat < bound);
    check(sel ? "wait_done_t" : "wait_done_a", 64'(done_of(sel)), 64'(1));
  endtask

  initial begin : main
    int lat;
    int h, l, p, extra;

    // Reset state.
    repeat (3) tick();
    check("rst_busy_a",   64'(busy_a),   64'(0));
    check("rst_done_a",   64'(done_a),   64'(0));
    check("rst_period_a", 64'(period_a), 64'(0));
    check("rst_high_a",   64'(high_a),   64'(0));
    check("rst_ovf_a",    64'(ovf_a),    64'(0));
    check("rst_busy_t",   64'(busy_t),   64'(0));
    check("rst_period_t", 64'(period_t), 64'(0));
    check("rst_ovf_t",    64'(ovf_t),    64'(0));
    resetn = 1'b1;
    repeat (3) tick();
    check("idle_busy_a", 64'(busy_a), 64'(0));

    // Basic period: 5 high / 5 low.
    set_wave(5, 5);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("basic_busy_after_start", 64'(busy_a), 64'(1));
    run(1'b0, 25, 0, lat);
    check("basic_within_25", 64'(lat <= 24), 64'(1));
    check("basic_period",    64'(period_a), 64'(10));
    check("basic_high",      64'(high_a),   64'(5));
    check("basic_ovf",       64'(ovf_a),    64'(0));
    check("basic_busy_drop", 64'(busy_a),   64'(0));
    tick();
    check("basic_done_1cyc", 64'(done_a), 64'(0));

    // ARM timeout on the short-timeout instance: input held low.
    wave_on = 1'b0;
    wlevel  = 1'b0;
    repeat (5) tick();
    start_t = 1'b1;
    run(1'b1, 70, 0, lat);
    $display("[TB] arm timeout: done after %0d cycles", lat);
    check("armto_latency", 64'(lat >= 49 && lat <= 53), 64'(1));
    check("armto_period",  64'(period_t), 64'(50));
    check("armto_high",    64'(high_t),   64'(0));
    check("armto_ovf",     64'(ovf_t),    64'(1));
    check("armto_a_idle",  64'(busy_a),   64'(0));

    // MEASURE timeout: one rise, then the input sticks high.
    repeat (4) tick();
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    repeat (4) tick();
    wlevel = 1'b1;
    run(1'b1, 90, 0, lat);
    check("measto_period", 64'(period_t), 64'(50));
    check("measto_high",   64'(high_t),   64'(50));
    check("measto_ovf",    64'(ovf_t),    64'(1));
    wlevel = 1'b0;
    repeat (6) tick();

    // Random square waves measured by both instances at once; every other
    // run also hammers start while the meters are busy.
    for (int i = 0; i < 8; i++) begin
      h = int'($urandom_range(2, 20));
      l = int'($urandom_range(2, 20));
      p = h + l;
      set_wave(h, l);
      start_a = 1'b1;
      start_t = 1'b1;
      run(1'b0, 3 * p + 12, (i % 2), lat);
      $display("[TB] rand %0d: h=%0d l=%0d -> period=%0d high=%0d ovf=%0d (t: %0d/%0d/%0d) lat=%0d",
               i, h, l, period_a, high_a, ovf_a, period_t, high_t, ovf_t, lat);
      check("rand_done_t_same", 64'(done_t),   64'(1));
      check("rand_period_a",    64'(period_a), 64'(p));
      check("rand_high_a",      64'(high_a),   64'(h));
      check("rand_ovf_a",       64'(ovf_a),    64'(0));
      check("rand_period_t",    64'(period_t), 64'(p));
      check("rand_high_t",      64'(high_t),   64'(h));
      check("rand_ovf_t",       64'(ovf_t),    64'(0));
      extra = 0;
      repeat (2 * p) begin
        tick();
        if (done_a === 1'b1) extra++;
      end
      check("rand_single_done", 64'(extra),  64'(0));
      check("rand_idle_after",  64'(busy_a), 64'(0));
    end

    // Divider-like wave with start held: back-to-back measurements.
    set_wave(40, 60);
    start_a = 1'b1;
    run(1'b0, 450, 2, lat);
    check("div1_period", 64'(period_a), 64'(100));
    check("div1_high",   64'(high_a),   64'(40));
    check("div1_ovf",    64'(ovf_a),    64'(0));
    tick();
    check("div_rearm_busy", 64'(busy_a), 64'(1));
    run(1'b0, 450, 2, lat);
    start_a = 1'b0;
    check("div2_period", 64'(period_a), 64'(100));
    check("div2_high",   64'(high_a),   64'(40));
    repeat (3) tick();
    check("div_idle_after_release", 64'(busy_a), 64'(0));

    // Reset in the middle of a measurement.
    set_wave(20, 20);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (35) tick();
    check("midrst_busy_before", 64'(busy_a), 64'(1));
    resetn = 1'b0;
    #1;
    check("midrst_busy_a",   64'(busy_a),   64'(0));
    check("midrst_done_a",   64'(done_a),   64'(0));
    check("midrst_period_a", 64'(period_a), 64'(0));
    check("midrst_high_a",   64'(high_a),   64'(0));
    check("midrst_ovf_a",    64'(ovf_a),    64'(0));
    check("midrst_period_t", 64'(period_t), 64'(0));
    check("midrst_high_t",   64'(high_t),   64'(0));
    wave_on = 1'b0;
    wlevel  = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    set_wave(6, 6);
    start_a = 1'b1;
    run(1'b0, 50, 0, lat);
    check("postrst_period", 64'(period_a), 64'(12));
    check("postrst_high",   64'(high_a),   64'(6));
    check("postrst_ovf",    64'(ovf_a),    64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
